// File: rtl/vram_write_scheduler.sv
// -----------------------------------------------------------------------------
// vram_write_scheduler
//
// Purpose:
//   Decouples CPU VRAM writes from the video timing. The CPU may write at any
//   time. Each write is queued in a small FIFO and replayed to the VRAM write
//   port only while the video timing reports the `writable` window as open.
//   Writes that arrive outside the window are deferred, never lost or torn.
//   VRAM receives the writes in exactly the order the CPU issued them.
//
// Ports:
//   clk           pixel clock
//   rst           synchronous, active-high reset
//   cpu_addr      CPU write address
//   cpu_data      CPU write data
//   cpu_we        CPU write strobe (already VRAM-qualified), one write per cycle
//   clr_overflow  clears the sticky overflow flag
//   writable      VRAM-writable window from video timing
//   vram_addr     address of the FIFO head entry
//   vram_data     data of the FIFO head entry
//   vram_we       VRAM write strobe (combinational, only while writable=1)
//   fifo_count    current FIFO occupancy
//   fifo_full     occupancy equals FIFO_DEPTH
//   overflow      sticky: a CPU write was dropped because the FIFO was full
//   busy          scheduler is not idle (entries pending or draining)
//
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// -----------------------------------------------------------------------------
module vram_write_scheduler #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_data,
  input  logic                  cpu_we,
  input  logic                  clr_overflow,
  input  logic                  writable,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]            vram_data,
  output logic                  vram_we,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  fifo_full,
  output logic                  overflow,
  output logic                  busy
);

  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W    = ADDR_WIDTH + 8;

  typedef enum logic [1:0] {
    ST_IDLE,   // FIFO empty
    ST_WAIT,   // entries pending, window closed
    ST_DRAIN   // replaying entries while the window is open
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q,  count_d;
  logic                 overflow_q, overflow_d;
  state_e               state_q,  state_d;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));

  // Full is judged on the pre-edge count, so a push in the same cycle as a
  // pop from a full FIFO is still rejected.
  assign push = cpu_we && !full;
  assign drop = cpu_we && full;

  // Pop is combinational so the strobe can never leave the writable window.
  // Gating with rst keeps VRAM untouched in the very cycle reset is sampled.
  assign pop  = (state_q == ST_DRAIN) && writable && !empty && !rst;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset; its contents are meaningless until
  // written, and leaving it unreset lets it map onto plain storage cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cpu_addr, cpu_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer, occupancy and overflow next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // Pointers are exactly log2(depth) bits wide and wrap naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end

    count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

    // A new drop beats a simultaneous clear.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = writable ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (writable) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_d == '0) begin
          // Last entry popped with no refill.
          state_d = ST_IDLE;
        end else if (!writable) begin
          // Head entry was not written this cycle and stays queued.
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Head entry is presented continuously; it is don't-care while empty.
  assign {vram_addr, vram_data} = mem_q[rd_ptr_q];
  assign vram_we    = pop;
  assign fifo_count = count_q;
  assign fifo_full  = full;
  assign overflow   = overflow_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
